// File: rtl/pixel_row_serializer.sv
// Double-buffered row capture with optional Gray decode, streamed out as
// OUTPUT_BUS_WIDTH-pixel words over a valid/ready bus.
module pixel_row_serializer #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int PIXEL_BITS        = 8,
    parameter int OUTPUT_BUS_WIDTH  = 2,
    parameter int GRAY_DECODE       = 1
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic                                    ROW_VALID,
    output logic                                    ROW_READY,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] DATA_IN,
    output logic                                    OUT_VALID,
    input  logic                                    OUT_READY,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]  DATA_OUT,
    output logic                                    OUT_FIRST,
    output logic                                    OUT_LAST,
    output logic                                    ROW_DROPPED
);
    localparam int ROW_W    = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int WORD_W   = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int WORDS    = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int IDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    generate
        if (PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH != 0) begin : g_bad_width
            $error("OUTPUT_BUS_WIDTH must divide PIXEL_ARRAY_WIDTH");
        end
    endgenerate

    state_t                         state, state_next;
    logic [ROW_W-1:0]               dec_row;
    logic [ROW_W-1:0]               bank [2];
    logic [WORDS-1:0][WORD_W-1:0]   rd_row;
    logic [WORD_W-1:0]              cur_word;
    logic                           wr_ptr, rd_ptr;
    logic [IDX_BITS-1:0]            idx;
    logic [1:0]                     count, count_next;
    logic                           accept, xfer, rel;

    // Per-pixel decode: each binary bit is the XOR of all Gray bits at or above it.
    generate
        if (GRAY_DECODE != 0) begin : g_gray
            for (genvar i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin : g_pix
                for (genvar j = 0; j < PIXEL_BITS; j++) begin : g_bit
                    assign dec_row[i*PIXEL_BITS+j] =
                        ^DATA_IN[i*PIXEL_BITS+PIXEL_BITS-1 : i*PIXEL_BITS+j];
                end
            end
        end else begin : g_raw
            assign dec_row = DATA_IN;
        end
    endgenerate

    assign rd_row = bank[rd_ptr];

    generate
        if (WORDS == 1) begin : g_one_word
            assign cur_word = rd_row[0];
        end else begin : g_multi_word
            assign cur_word = rd_row[idx];
        end
    endgenerate

    assign ROW_READY = (count != 2'd2);
    assign accept    = ROW_VALID & ROW_READY;
    assign xfer      = (state == SEND) & OUT_READY;
    assign rel       = xfer & (idx == LAST_IDX);

    always_comb begin
        count_next = count;
        case ({accept, rel})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Look at the post-edge fill so a fresh row shows up one cycle after
    // acceptance and a back-to-back row follows the last word with no bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (count_next != 2'd0) ? SEND : IDLE;
            SEND:    state_next = (count_next != 2'd0) ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        OUT_VALID = 1'b0;
        OUT_FIRST = 1'b0;
        OUT_LAST  = 1'b0;
        DATA_OUT  = '0;
        if (state == SEND) begin
            OUT_VALID = 1'b1;
            OUT_FIRST = (idx == '0);
            OUT_LAST  = (idx == LAST_IDX);
            DATA_OUT  = cur_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            idx         <= '0;
            count       <= 2'd0;
            ROW_DROPPED <= 1'b0;
        end else begin
            count       <= count_next;
            ROW_DROPPED <= ROW_VALID & ~ROW_READY;
            if (accept) wr_ptr <= ~wr_ptr;
            if (rel) begin
                idx    <= '0;
                rd_ptr <= ~rd_ptr;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Bank contents need no reset; emptiness is tracked by count.
    always_ff @(posedge CLK) begin
        if (accept) bank[wr_ptr] <= dec_row;
    end
endmodule

// File: tb/tb_pixel_row_serializer.sv
// Randomized bench for pixel_row_serializer against a row-queue model,
// plus literal checks on fixed scenarios and a raw single-word variant.
module tb_pixel_row_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1, rv = 1'b0, ordy = 1'b0;
    logic [31:0] din = '0;
    logic        rrdy, ov, ofirst, olast, odrop;
    logic [7:0]  dout;

    logic        rst2 = 1'b1, rv2 = 1'b0, ordy2 = 1'b0;
    logic [31:0] di2 = '0;
    logic        rrdy2, ov2, ofirst2, olast2, odrop2;
    logic [31:0] dout2;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pixel_row_serializer #(.PIXEL_ARRAY_WIDTH(8), .PIXEL_BITS(4),
                           .OUTPUT_BUS_WIDTH(2), .GRAY_DECODE(1)) dut (
        .CLK(clk), .RESET(rst), .ROW_VALID(rv), .ROW_READY(rrdy), .DATA_IN(din),
        .OUT_VALID(ov), .OUT_READY(ordy), .DATA_OUT(dout), .OUT_FIRST(ofirst),
        .OUT_LAST(olast), .ROW_DROPPED(odrop));

    pixel_row_serializer #(.PIXEL_ARRAY_WIDTH(8), .PIXEL_BITS(4),
                           .OUTPUT_BUS_WIDTH(8), .GRAY_DECODE(0)) dut_raw (
        .CLK(clk), .RESET(rst2), .ROW_VALID(rv2), .ROW_READY(rrdy2), .DATA_IN(di2),
        .OUT_VALID(ov2), .OUT_READY(ordy2), .DATA_OUT(dout2), .OUT_FIRST(ofirst2),
        .OUT_LAST(olast2), .ROW_DROPPED(odrop2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Gray -> binary as b = g ^ g>>1 ^ g>>2 ^ ...
    function automatic logic [31:0] model_dec(input logic [31:0] raw);
        logic [31:0] r;
        logic [3:0]  g, b;
        r = '0;
        for (int p = 0; p < 8; p++) begin
            g = raw[p*4 +: 4];
            b = '0;
            for (int s = 0; s < 4; s++) b = b ^ (g >> s);
            r[p*4 +: 4] = b;
        end
        return r;
    endfunction

    // Model: queue of stored rows; head row is being sent, midx is its word.
    logic [31:0] mq[$];
    int          midx = 0;
    logic        e_drop = 1'b0, chk_en = 1'b0, m_full, m_had;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            midx   = 0;
            e_drop = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_had  = (mq.size() > 0);
            m_full = (mq.size() >= 2);
            e_drop = rv && m_full;
            if (m_had && ordy) begin
                midx++;
                if (midx == 4) begin
                    void'(mq.pop_front());
                    midx = 0;
                end
            end
            if (rv && !m_full) mq.push_back(model_dec(din));
        end
    end

    logic [31:0] hr;
    logic [7:0]  ew;
    logic        evld;
    always @(negedge clk) begin
        if (chk_en) begin
            evld = (mq.size() > 0);
            ew   = '0;
            if (evld) begin
                hr = mq[0];
                ew = hr[midx*8 +: 8];
            end
            chk("valid", 32'(ov), 32'(evld));
            chk("data", 32'(dout), 32'(ew));
            chk("first", 32'(ofirst), 32'(evld && midx == 0));
            chk("last", 32'(olast), 32'(evld && midx == 3));
            chk("row_ready", 32'(rrdy), 32'(mq.size() < 2));
            chk("dropped", 32'(odrop), 32'(e_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lit [4];
    int n, rises;
    logic prev;

    initial begin
        lit[0] = 8'h32; lit[1] = 8'h54; lit[2] = 8'h76; lit[3] = 8'hF8;
        chk("pin_decode", model_dec(32'h8C457623), 32'hF8765432);

        // Reset then one known row
        ordy = 1'b1;
        tick(); tick();
        chk("reset_valid", 32'(ov), 32'd0);
        chk("reset_ready", 32'(rrdy), 32'd1);
        chk("reset_data", 32'(dout), 32'd0);
        rst = 1'b0; rv = 1'b1; din = 32'h8C457623;
        tick();
        rv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", 32'(ov), 32'd1);
            chk("t1_word", 32'(dout), 32'(lit[k]));
            chk("t1_first", 32'(ofirst), 32'(k == 0));
            chk("t1_last", 32'(olast), 32'(k == 3));
            tick();
        end
        chk("t1_idle", 32'(ov), 32'd0);

        // Two back-to-back rows: 8 words in one unbroken burst
        rv = 1'b1; din = $urandom;
        tick();
        n = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ov) n++;
            if (ov && !prev) rises++;
            prev = ov;
            rv = (i == 0);
            din = $urandom;
            tick();
        end
        chk("t2_words", 32'(n), 32'd8);
        chk("t2_bursts", 32'(rises), 32'd1);

        // Stalls with a 1,0,0,1 ready pattern
        for (int i = 0; i < 48; i++) begin
            ordy = (i % 4 == 0) || (i % 4 == 3);
            rv   = $urandom_range(0, 1);
            din  = $urandom;
            tick();
        end
        rv = 1'b0; ordy = 1'b1;
        repeat (12) tick();

        // Three rows into a blocked sink: third is dropped
        ordy = 1'b0; rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = $urandom;
            tick();
        end
        rv = 1'b0;
        chk("t4_drop", 32'(odrop), 32'd1);
        chk("t4_ready", 32'(rrdy), 32'd0);
        tick();
        chk("t4_drop_pulse", 32'(odrop), 32'd0);
        ordy = 1'b1; n = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov) n++;
            tick();
        end
        chk("t4_drained", 32'(n), 32'd8);

        // Reset mid-row with a second row buffered
        rv = 1'b1; din = $urandom;
        tick();
        din = $urandom;
        tick();
        rv = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(ov), 32'd0);
        chk("t5_ready", 32'(rrdy), 32'd1);
        rv = 1'b1; din = $urandom;
        tick();
        rv = 1'b0;
        chk("t5_restart", 32'(ofirst), 32'd1);
        repeat (6) tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rv   = ($urandom_range(0, 2) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 199) == 0);
            din  = $urandom;
            tick();
        end
        rst = 1'b0; rv = 1'b0; ordy = 1'b1;
        repeat (12) tick();
        chk("rand_idle", 32'(ov), 32'd0);

        // Raw single-word variant
        tick();
        rst2 = 1'b0;
        chk("t6_reset", 32'(ov2), 32'd0);
        rv2 = 1'b1; di2 = 32'hA5C31E70; ordy2 = 1'b0;
        tick();
        rv2 = 1'b0;
        chk("t6_data", dout2, 32'hA5C31E70);
        chk("t6_first", 32'(ofirst2), 32'd1);
        chk("t6_last", 32'(olast2), 32'd1);
        tick();
        chk("t6_stall_valid", 32'(ov2), 32'd1);
        chk("t6_stall_data", dout2, 32'hA5C31E70);
        ordy2 = 1'b1;
        tick();
        chk("t6_done", 32'(ov2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
